// File: rtl/eth_pkg.sv
// eth_pkg: shared constants, write-side state type and the stored-length helper
// for the Ethernet receive frame buffer.
// Build option: ETH_RX_STRIP_FCS_EN removes the 4 FCS bytes from every committed frame.
package eth_pkg;

  localparam int MIN_LEN   = 64;    // shortest legal frame, FCS included
  localparam int MAX_LEN   = 1522;  // longest legal frame, FCS included
  localparam int FCS_BYTES = 4;
  localparam int LEN_W     = 11;    // wide enough for MAX_LEN

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DROP = 2'd2
  } wr_state_e;

  // Length recorded in the frame queue for a frame of 'count' received bytes.
  function automatic logic [LEN_W-1:0] stored_len(input logic [LEN_W-1:0] count);
`ifdef ETH_RX_STRIP_FCS_EN
    return count - LEN_W'(FCS_BYTES);
`else
    return count;
`endif
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO. dout always presents the head entry;
// push while full and pop while empty are ignored. count reports occupancy.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Occupancy flags from extended pointers: equal means empty, MSB-only difference means full.
  always_comb begin
    empty   = (wr_ptr == rd_ptr);
    full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    count   = wr_ptr - rd_ptr;
    do_push = push && !full;
    do_pop  = pop && !empty;
    dout    = mem[rd_ptr[AW-1:0]];
  end

  // Storage write; no reset so it maps onto distributed RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  // Pointer advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

endmodule

// File: rtl/eth_rx_frame_buf.sv
// eth_rx_frame_buf: stores received Ethernet frames, releases only those the CRC
// checker marks good and that meet length limits; discarded frames are counted.
// Build option: ETH_RX_STRIP_FCS_EN drops the trailing FCS from committed frames.
//
// Output handshake: a byte moves on every rising edge where m_valid && m_ready.
// While m_valid is high and m_ready low, m_data and m_last hold their values and
// m_valid stays high. m_last marks the final byte of a frame.
module eth_rx_frame_buf
  import eth_pkg::*;
#(
  parameter int DEPTH  = 4096,
  parameter int FRAMES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        data_valid,
  input  logic [7:0]  data_in,
  input  logic        fcs_good,
  input  logic        fcs_bad,
  output logic        m_valid,
  output logic [7:0]  m_data,
  output logic        m_last,
  input  logic        m_ready,
  output logic [15:0] drop_count,
  output wr_state_e   dbg_state
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;
  localparam int QCW   = $clog2(FRAMES) + 1;

  logic [7:0]       mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr, commit_ptr, end_ptr;
  logic [LEN_W-1:0] byte_cnt, rd_idx;
  wr_state_e        state;

  logic             accept, fcs_any, store_full, wr_en, commit_ok;
  logic             q_full, q_empty, q_pop;
  logic [LEN_W-1:0] q_din, head_len;
  logic [QCW-1:0]   q_count;
  logic             out_free, last_xfer, load;

  assign dbg_state = state;

  // Write-side decode: byte acceptance, store-full test, commit qualification.
  always_comb begin
    accept     = data_valid && !stall;
    fcs_any    = fcs_good || fcs_bad;
    store_full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    wr_en      = 1'b0;
    case (state)
      IDLE:    wr_en = accept && !q_full && !store_full;
      RECV:    wr_en = accept && !fcs_any && !store_full && (byte_cnt != LEN_W'(MAX_LEN));
      default: wr_en = 1'b0;
    endcase
    // fcs_bad wins when both pulses arrive together.
    commit_ok = (state == RECV) && fcs_good && !fcs_bad && (byte_cnt >= LEN_W'(MIN_LEN));
    q_din     = stored_len(byte_cnt);
`ifdef ETH_RX_STRIP_FCS_EN
    end_ptr   = wr_ptr - PTR_W'(FCS_BYTES);
`else
    end_ptr   = wr_ptr;
`endif
  end

  // Write FSM: collect a frame, then commit it or roll back to the last commit point.
  // Queue space is only checked at frame start: nothing else pushes, so it cannot fill meanwhile.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      byte_cnt   <= '0;
      drop_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (wr_en) begin
              wr_ptr   <= wr_ptr + PTR_W'(1);
              byte_cnt <= LEN_W'(1);
              state    <= RECV;
            end else begin
              state    <= DROP;
            end
          end
        end
        RECV: begin
          if (fcs_any) begin
            if (commit_ok) begin
              commit_ptr <= end_ptr;
              wr_ptr     <= end_ptr;
            end else begin
              wr_ptr <= commit_ptr;
              if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
            end
            state <= IDLE;
          end else if (accept) begin
            if (wr_en) begin
              wr_ptr   <= wr_ptr + PTR_W'(1);
              byte_cnt <= byte_cnt + LEN_W'(1);
            end else begin
              state <= DROP;
            end
          end
        end
        DROP: begin
          if (fcs_any) begin
            wr_ptr <= commit_ptr;
            if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Byte store write port.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) mem[wr_ptr[AW-1:0]] <= data_in;
  end

  sync_fifo #(
    .WIDTH (LEN_W),
    .DEPTH (FRAMES)
  ) u_len_q (
    .clk   (clk),
    .reset (reset),
    .push  (commit_ok),
    .din   (q_din),
    .pop   (q_pop),
    .dout  (head_len),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  // Read-side decode: load the output register whenever it is empty or being drained.
  // On the final-byte transfer the next frame's length is the second queue entry, so
  // its first byte can be loaded in the same cycle as the pop.
  always_comb begin
    out_free  = !m_valid || m_ready;
    last_xfer = m_valid && m_ready && m_last;
    q_pop     = last_xfer;
    load      = 1'b0;
    if (out_free) begin
      if (last_xfer) load = (q_count >= QCW'(2));
      else           load = !q_empty && (rd_idx < head_len);
    end
  end

  // Output register fed straight from the byte store; only committed bytes are ever read.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr  <= '0;
      rd_idx  <= '0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      m_data  <= '0;
    end else if (load) begin
      m_data  <= mem[rd_ptr[AW-1:0]];
      rd_ptr  <= rd_ptr + PTR_W'(1);
      m_valid <= 1'b1;
      if (last_xfer) begin
        // Committed frames hold at least MIN_LEN-FCS_BYTES bytes, so a first byte is never last.
        rd_idx <= LEN_W'(1);
        m_last <= 1'b0;
      end else begin
        rd_idx <= rd_idx + LEN_W'(1);
        m_last <= ((rd_idx + LEN_W'(1)) == head_len);
      end
    end else if (out_free) begin
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      if (last_xfer) rd_idx <= '0;
    end
  end

endmodule

// File: doc/eth_rx_frame_buf.md
ETH_RX_FRAME_BUF -- requirements
Module: eth_rx_frame_buf

Interface
REQ-001 Parameter DEPTH, 4096, byte storage entries, power of 2.
REQ-002 Parameter FRAMES, 16, committed-frame length queue entries, power of 2.
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 stall  input  1  byte stream pause; same signal driven to the CRC checker.
REQ-006 data_valid  input  1  frame-in-progress; same signal driven to the CRC checker.
REQ-007 data_in  input  8  frame byte; accepted when data_valid && !stall.
REQ-008 fcs_good  input  1  one-cycle pulse from CRC checker, cycle after last byte.
REQ-009 fcs_bad  input  1  one-cycle pulse from CRC checker, cycle after last byte.
REQ-010 m_valid, m_data[7:0], m_last  output  1/8/1  frame output stream; m_last on final byte.
REQ-011 m_ready  input  1  downstream accept; transfer when m_valid && m_ready.
REQ-012 drop_count  output  16  saturating count of discarded frames.

Function
REQ-013 Write FSM states IDLE, RECV, DROP; accepted byte in IDLE enters RECV, or DROP if length queue full.
REQ-014 RECV: each accepted byte written at wr_ptr, wr_ptr and 11-bit byte count increment.
REQ-015 RECV: byte accepted with byte store full (wr_ptr - rd_ptr == DEPTH) or count reaching MAX_LEN+1 -> DROP, byte not written.
REQ-016 DROP: accepted bytes ignored; state held until fcs_good or fcs_bad.
REQ-017 fcs_good in RECV with count >= MIN_LEN: commit -- commit_ptr <= end pointer, length pushed to queue, -> IDLE.
REQ-018 fcs_bad, or fcs_good in DROP, or count < MIN_LEN: wr_ptr <= commit_ptr, drop_count += 1 (saturate at 0xFFFF), -> IDLE.
REQ-019 fcs_good/fcs_bad in IDLE ignored; both high in same cycle treated as fcs_bad.
REQ-020 Pointers are log2(DEPTH)+1 bits; wrap modulo 2*DEPTH; full/empty by MSB compare.
REQ-021 Read side: m_valid asserted only while a committed length is at queue head; output byte registered.
REQ-022 Commit in cycle N -> m_valid high in cycle N+2 when queue previously empty and output idle.
REQ-023 m_data/m_last stable while m_valid && !m_ready; next byte presented the cycle after each transfer (full throughput).
REQ-024 m_last high exactly on byte number <length>; queue pops on that transfer; back-to-back frames with no bubble.
REQ-025 Uncommitted bytes never reach the output; reads never pass commit_ptr.

Reset
REQ-026 Reset: state IDLE, all pointers 0, queue empty, m_valid 0, m_last 0, m_data 0, drop_count 0.
REQ-027 Reset mid-frame or mid-output: partial and committed frames discarded, no drop_count increment.

Configuration
REQ-028 Macro ETH_RX_STRIP_FCS_EN defined: on commit, end pointer = wr_ptr - 4 and wr_ptr <= wr_ptr - 4; stored length = count - 4.
REQ-029 Macro undefined: end pointer = wr_ptr; stored length = count (FCS delivered).
REQ-030 MIN_LEN/MAX_LEN checks apply to count including FCS in both builds.

Structure
REQ-031 Package eth_pkg: MIN_LEN=64, MAX_LEN=1522, FCS_BYTES=4, LEN_W=11, write-FSM state enum.
REQ-032 Length queue is sub-module sync_fifo (WIDTH=LEN_W, DEPTH=FRAMES); byte store inferred RAM in this module.

Verification
REQ-033 64-byte frame, fcs_good -> 60 bytes out (strip) / 64 (no strip), m_last on last, drop_count 0.
REQ-034 100-byte frame, fcs_bad -> no output, drop_count 1, wr_ptr back to commit_ptr.
REQ-035 Two 64-byte frames back-to-back, m_ready held 1 -> contiguous m_valid, two m_last pulses, no bubble.
REQ-036 DEPTH=128, m_ready 0, 2x64-byte frames then a third -> third dropped, drop_count 1, first two intact after m_ready 1.
REQ-037 40-byte frame with fcs_good -> runt dropped, drop_count 1; stall pulses mid-frame -> no duplicated bytes.
REQ-038 Reset asserted mid-RECV of 200-byte frame -> m_valid 0, next 64-byte frame output correctly.
